// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Single-outstanding instruction fetch unit with a small {pc, inst}
//            buffer, redirect handling and in-flight response discard.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int          AW      = $clog2(BUF_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(BUF_DEPTH);
    localparam logic [31:0] C_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_pc_mem   [BUF_DEPTH];
    logic [31:0]   r_inst_mem [BUF_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request is only issued when a buffer slot is free, so the slot is
    // effectively reserved for the whole time the request is outstanding.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!redirect && (r_count < C_DEPTH)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    w_state_nxt = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_pop = (r_count != '0) && inst_ready && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wptr     <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= r_fetch_pc;
            r_inst_mem[r_wptr] <= imem_rdata;
        end
    end

    assign imem_req   = w_issue && !rst;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_inst_mem[r_rptr] : C_NOP;
    assign inst_pc    = inst_valid ? r_pc_mem[r_rptr]   : 32'h0000_0000;

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 BUF_DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory, one-cycle pulse.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_ack  input  1  response strobe; exactly one per request, >=1 cycle after it.
REQ-008 imem_rdata  input  32  fetched instruction, valid while imem_ack=1.
REQ-009 redirect  input  1  control-flow change from the execute/branch stage.
REQ-010 redirect_pc  input  32  new fetch target, sampled while redirect=1.
REQ-011 inst_valid  output  1  buffer head holds an instruction for decode.
REQ-012 inst_ready  input  1  decode/control unit accepts head this cycle.
REQ-013 inst  output  32  head instruction word, fed to the control unit.
REQ-014 inst_pc  output  32  PC of head instruction.

Function
REQ-015 FSM states IDLE, WAIT, DROP; fetch_pc register; FIFO of {pc, inst}, BUF_DEPTH entries.
REQ-016 IDLE: imem_req=1, imem_addr=fetch_pc iff occupancy<BUF_DEPTH and redirect=0; issuing moves to WAIT, else stays IDLE.
REQ-017 imem_req SHALL be 0 in WAIT and DROP (max one outstanding request).
REQ-018 WAIT, imem_ack=1, redirect=0: push {fetch_pc, imem_rdata}, fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go IDLE.
REQ-019 Slot reserved at issue; push never occurs while full; no overflow possible.
REQ-020 inst_valid = (occupancy!=0); inst/inst_pc = head entry; when empty inst=32'h0000_0013 (NOP), inst_pc=0.
REQ-021 inst_valid & inst_ready pops head; simultaneous push and pop leaves occupancy unchanged; FIFO pointers wrap modulo BUF_DEPTH.
REQ-022 Outputs depend only on registered state (no combinational path imem_rdata->inst or inst_ready->imem_req).
REQ-023 redirect has priority over all other events: next edge clears FIFO (occupancy 0) and loads fetch_pc={redirect_pc[31:2],2'b00}.
REQ-024 Handshake completing in a redirect cycle counts as delivered; no entry present at the redirect edge survives it.
REQ-025 Redirect in WAIT with imem_ack=0 -> DROP; with imem_ack=1 -> response discarded, go IDLE.
REQ-026 DROP: next imem_ack discarded, go IDLE; further redirect in DROP reloads fetch_pc, stays DROP.
REQ-027 Redirect in IDLE suppresses that cycle's request; fetch resumes from new PC next cycle.
REQ-028 imem_ack in IDLE SHALL be ignored (no push, no state change).
REQ-029 Steady-state throughput with 1-cycle memory: one instruction per 2 cycles.

Reset
REQ-030 rst=1 asynchronously forces IDLE, fetch_pc=RESET_PC, occupancy 0, inst_valid=0, inst=32'h0000_0013, inst_pc=0.
REQ-031 imem_req=0 while rst=1; first request (addr RESET_PC) in first cycle after deassertion.
REQ-032 Reset mid-WAIT abandons outstanding response; its late ack falls under REQ-028.

Verification
REQ-033 Reset release, 1-cycle memory, inst_ready=1 -> requests at 0x0,0x4,0x8; inst_pc sequence 0x0,0x4,0x8 with matching rdata.
REQ-034 inst_ready=0 -> exactly 2 fetches then imem_req stays 0; inst_ready=1 -> entries drain in order, fetching resumes.
REQ-035 Redirect to 0x0000_1003 in WAIT, ack 3 cycles later -> ack discarded, next imem_addr=0x0000_1000, FIFO empty meanwhile.
REQ-036 Redirect and imem_ack same cycle, FIFO holding 1 entry -> no push, inst_valid=0 next cycle, next fetch at redirect target.
REQ-037 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-038 rst asserted mid-WAIT with 1 entry buffered -> immediate inst_valid=0, NOP output; stale ack ignored; refetch from RESET_PC.
